// File: rtl/phase_freq_estimator.sv
// phase_freq_estimator
// Estimates the per-sample phase increment of an incoming phase stream by
// averaging 2^LOG2N consecutive wrap-around phase deltas. The estimate is
// scaled to the PW-bit accumulator of a matching NCO and held until the
// consumer takes it.
//
// Ports
//   i_clk        single clock, rising edge
//   i_reset      synchronous active-high reset
//   i_ce         i_phase carries a valid sample this cycle
//   i_phase      unsigned phase sample, modulo 2^OW
//   i_ready      consumer accepts o_increment (only looked at while holding)
//   o_valid      o_increment / o_overflow hold a new estimate
//   o_increment  estimated increment in PW-bit accumulator units (PW-1 bits)
//   o_overflow   the window contained a delta of half a turn or more
module phase_freq_estimator #(
    parameter int unsigned OW    = 20,
    parameter int unsigned PW    = 32,
    parameter int unsigned LOG2N = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic [OW-1:0] i_phase,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [PW-2:0] o_increment,
    output logic          o_overflow
);

    localparam int unsigned SW = OW + LOG2N;          // delta sum width
    localparam int unsigned SH = PW - OW - LOG2N;     // sum -> accumulator units
    localparam int unsigned CW = (LOG2N > 0) ? LOG2N : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2N) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    logic [OW-1:0]   r_prev;
    logic [SW-1:0]   r_sum;
    logic [CW-1:0]   r_cnt;
    logic            r_sticky;
    logic            r_valid;
    logic [PW-2:0]   r_inc;
    logic            r_ovf;

    state_t          w_state;
    logic [OW-1:0]   w_prev;
    logic [SW-1:0]   w_sum;
    logic [CW-1:0]   w_cnt;
    logic            w_sticky;
    logic            w_valid;
    logic [PW-2:0]   w_inc;
    logic            w_ovf;

    logic [OW-1:0]   w_delta;
    logic [SW-1:0]   w_final_sum;
    logic            w_final_ovf;
    logic [PW-2:0]   w_est;

    // Modulo-2^OW subtraction gives the wrap-correct unsigned delta.
    always_comb begin
        w_delta     = i_phase - r_prev;
        w_final_sum = r_sum + SW'(w_delta);
        w_final_ovf = r_sticky | w_delta[OW-1];
        w_est       = (PW-1)'(PW'(w_final_sum) << SH);
    end

    // State register and all datapath/output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_prev   <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_valid  <= 1'b0;
            r_inc    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_prev   <= w_prev;
            r_sum    <= w_sum;
            r_cnt    <= w_cnt;
            r_sticky <= w_sticky;
            r_valid  <= w_valid;
            r_inc    <= w_inc;
            r_ovf    <= w_ovf;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state  = r_state;
        w_prev   = r_prev;
        w_sum    = r_sum;
        w_cnt    = r_cnt;
        w_sticky = r_sticky;
        w_valid  = r_valid;
        w_inc    = r_inc;
        w_ovf    = r_ovf;

        unique case (r_state)
            S_IDLE: begin
                // First sample only primes the previous phase.
                if (i_ce) begin
                    w_prev  = i_phase;
                    w_state = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (i_ce) begin
                    w_prev = i_phase;
                    if (r_cnt == CNT_LAST) begin
                        // Window complete: present estimate, restart the window.
                        w_valid  = 1'b1;
                        w_ovf    = w_final_ovf;
                        w_inc    = w_final_ovf ? '1 : w_est;
                        w_sum    = '0;
                        w_cnt    = '0;
                        w_sticky = 1'b0;
                        w_state  = S_HOLD;
                    end else begin
                        w_sum    = w_final_sum;
                        w_cnt    = r_cnt + CW'(1);
                        w_sticky = w_final_ovf;
                    end
                end
            end

            S_HOLD: begin
                // Samples keep prev_phase current but are not accumulated.
                if (i_ce) begin
                    w_prev = i_phase;
                end
                if (i_ready) begin
                    w_valid = 1'b0;
                    w_cnt   = '0;
                    w_state = S_ACCUM;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_valid     = r_valid;
    assign o_increment = r_inc;
    assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_phase_freq_estimator.sv
module tb_phase_freq_estimator;

    localparam int unsigned OW = 20;
    localparam int unsigned PW = 32;

    logic          clk;
    logic          i_reset;
    logic          i_ce;
    logic [OW-1:0] i_phase;
    logic          i_ready;
    logic          o_valid;
    logic [PW-2:0] o_increment;
    logic          o_overflow;

    phase_freq_estimator #(.OW(OW), .PW(PW), .LOG2N(4)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_ce        (i_ce),
        .i_phase     (i_phase),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_increment (o_increment),
        .o_overflow  (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-2:0] inc;
        logic          ovf;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks each new estimate against the queue, then checks the
    // held outputs stay stable for as long as o_valid stays high.
    logic          mon_prev_valid = 1'b0;
    logic [PW-2:0] mon_inc;
    logic          mon_ovf;

    always @(negedge clk) begin
        if (o_valid && !mon_prev_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got inc=%h ovf=%0d at cycle %0d, required no estimate",
                         o_increment, o_overflow, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (o_increment !== e.inc) begin
                    n_err++;
                    $display("FAIL increment: got %h, required %h", o_increment, e.inc);
                end
                n_cmp++;
                if (o_overflow !== e.ovf) begin
                    n_err++;
                    $display("FAIL overflow: got %0d, required %0d", o_overflow, e.ovf);
                end
                n_cmp++;
                if (cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL latency: valid at cycle %0d, required %0d", cyc, e.cyc);
                end
            end
            mon_inc = o_increment;
            mon_ovf = o_overflow;
        end else if (o_valid && mon_prev_valid) begin
            n_cmp++;
            if (o_increment !== mon_inc || o_overflow !== mon_ovf) begin
                n_err++;
                $display("FAIL hold_stable: got inc=%h ovf=%0d, required inc=%h ovf=%0d",
                         o_increment, o_overflow, mon_inc, mon_ovf);
            end
        end
        mon_prev_valid = o_valid;
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic drive(input logic ce, input logic [OW-1:0] ph, input logic rdy);
        i_ce    = ce;
        i_phase = ph;
        i_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Estimate expected right after the edge just driven.
    task automatic expect_est(input logic [PW-2:0] inc, input logic ovf);
        exp_t e;
        e.inc = inc;
        e.ovf = ovf;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Reset asserted together with i_ce/i_ready; outputs must clear.
    task automatic do_reset();
        i_reset = 1'b1;
        drive(1'b1, 20'h12345, 1'b1);
        i_reset = 1'b0;
        i_ce    = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_increment !== '0 || o_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%0d inc=%h ovf=%0d, required 0/0/0",
                     o_valid, o_increment, o_overflow);
        end
    endtask

    // n consecutive samples start, start+step, ...; returns the last phase.
    task automatic tone(input logic [OW-1:0] start, input logic [OW-1:0] step,
                        input int n, input logic rdy, output logic [OW-1:0] last);
        logic [OW-1:0] ph;
        ph = start;
        for (int k = 0; k < n; k++) begin
            drive(1'b1, ph, rdy);
            last = ph;
            ph   = ph + step;
        end
    endtask

    initial begin
        logic [OW-1:0] last;
        logic [OW-1:0] ph;
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] last;
        logic [OW-1:0] ph;
        i_reset = 1'b1;
        i_ce    = 1'b0;
        i_phase = '0;
        i_ready = 1'b0;
        drive(1'b0, '0, 1'b0);
        do_reset();

        // Steady tone, step 0x100: 16 deltas sum 0x1000, << 8 = 0x100000.
        tone(20'h00000, 20'h00100, 17, 1'b1, last);
        expect_est(31'h00100000, 1'b0);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);

        // Wrap-around through 2^20.
        do_reset();
        tone(20'hFFF80, 20'h00100, 17, 1'b1, last);
        expect_est(31'h00100000, 1'b0);
        drive(1'b0, '0, 1'b1);

        // Overflow window (one half-turn delta), then a clean window at step 0x200.
        do_reset();
        ph = '0;
        drive(1'b1, ph, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            ph = ph + ((k == 6) ? 20'h80000 : 20'h00100);
            drive(1'b1, ph, 1'b1);
        end
        expect_est(31'h7FFFFFFF, 1'b1);
        tone(ph + 20'h00200, 20'h00200, 17, 1'b1, last);
        expect_est(31'h00200000, 1'b0);
        drive(1'b0, '0, 1'b1);

        // Backpressure: 5 held cycles with samples, handshake sample primes,
        // then exactly 16 samples at step 0x300 give 0x300000.
        do_reset();
        tone(20'h00000, 20'h00100, 17, 1'b0, last);
        expect_est(31'h00100000, 1'b0);
        tone(last + 20'h00100, 20'h00100, 5, 1'b0, last);
        drive(1'b1, 20'h40000, 1'b1);
        tone(20'h40300, 20'h00300, 16, 1'b1, last);
        expect_est(31'h00300000, 1'b0);
        drive(1'b0, '0, 1'b1);

        // Gaps: alternate valid samples with ignored garbage.
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            drive(1'b1, OW'(k * 32'h100), 1'b1);
            if (k == 16) expect_est(31'h00100000, 1'b0);
            else         drive(1'b0, 20'hABCDE, 1'b1);
        end
        drive(1'b0, '0, 1'b1);

        // Reset after 8 deltas: partial window discarded, 17 new samples needed.
        do_reset();
        tone(20'h00000, 20'h00100, 9, 1'b1, last);
        do_reset();
        tone(20'h55555, 20'h00400, 17, 1'b1, last);
        expect_est(31'h00400000, 1'b0);
        drive(1'b0, '0, 1'b1);

        // Reset during hold drops the presented estimate.
        do_reset();
        tone(20'h00000, 20'h00080, 17, 1'b0, last);
        expect_est(31'h00080000, 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b1, 20'h11111, 1'b0);
        do_reset();
        tone(20'h00000, 20'h00100, 17, 1'b1, last);
        expect_est(31'h00100000, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b1);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_estimates: got %0d unseen, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phase_freq_estimator.md
PHASE_FREQ_ESTIMATOR -- requirements
Module: phase_freq_estimator

Interface
REQ-001 SHALL have parameter OW, default 20: input phase word width in bits.
REQ-002 SHALL have parameter PW, default 32: phase accumulator width of the matching NCO; the output increment is PW-1 bits.
REQ-003 SHALL have parameter LOG2N, default 4: log2 of the averaging window length in phase deltas. Legal only when PW-OW >= LOG2N.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_ce, input, 1 bit: i_phase is a valid sample this cycle.
REQ-007 SHALL have port i_phase, input, OW bits: unsigned phase sample, modulo 2^OW.
REQ-008 SHALL have port i_ready, input, 1 bit: the consumer accepts o_increment.
REQ-009 SHALL have port o_valid, output, 1 bit: o_increment and o_overflow hold a new estimate.
REQ-010 SHALL have port o_increment, output, PW-1 bits: estimated per-sample phase increment, in PW-bit accumulator units.
REQ-011 SHALL have port o_overflow, output, 1 bit: the window contained an out-of-range delta.

Function
REQ-012 SHALL implement three states: IDLE (no previous sample), ACCUM (summing deltas) and HOLD (estimate presented).
REQ-013 In IDLE, on i_ce SHALL store i_phase as prev_phase and go to ACCUM, with no delta accumulated.
REQ-014 In ACCUM, on i_ce SHALL compute delta = (i_phase - prev_phase) mod 2^OW, unsigned, wrap-around correct.
REQ-015 In ACCUM, on i_ce SHALL add delta into a sum of width OW+LOG2N, increment the delta counter and update prev_phase to i_phase.
REQ-016 In ACCUM, if delta[OW-1]=1 SHALL set a sticky window-overflow flag.
REQ-017 On the 2^LOG2N-th delta of a window, SHALL register the estimate, assert o_valid on the next cycle and enter HOLD.
REQ-018 When registering the estimate, SHALL clear the sum, the counter and the sticky flag.
REQ-019 Estimate without overflow: o_increment = (final sum << (PW-OW-LOG2N)), truncated to PW-1 bits, and o_overflow=0.
REQ-020 Estimate with overflow: o_increment = all ones (2^(PW-1)-1) and o_overflow=1.
REQ-021 "Final sum" in REQ-019 SHALL include the last delta of the window.
REQ-022 In HOLD, o_valid, o_increment and o_overflow SHALL stay stable until the cycle where o_valid&&i_ready.
REQ-023 In HOLD, i_ce samples SHALL update prev_phase only; they are not accumulated and not counted.
REQ-024 On o_valid&&i_ready SHALL deassert o_valid on the next cycle and go to ACCUM with the counter at 0.
REQ-025 A sample with i_ce in the handshake cycle SHALL only update prev_phase.
REQ-026 i_ready SHALL be ignored outside HOLD.
REQ-027 Cycles with i_ce=0 SHALL leave all state unchanged.
REQ-028 Latency: o_valid SHALL rise exactly one cycle after the clock edge that samples the final delta of a window.

Reset
REQ-029 On i_reset=1 at a clock edge SHALL go to IDLE and clear o_valid, o_increment, o_overflow, the sum, the counter, the sticky flag and prev_phase to 0.
REQ-030 Reset SHALL take priority over i_ce and i_ready in the same cycle.
REQ-031 Reset mid-window or during HOLD SHALL discard the partial or presented estimate; the first i_ce afterwards only primes.

Verification
REQ-032 Steady tone: i_ce every cycle, phases 0x00000, 0x00100, ... (17 samples), i_ready=1 -> one o_valid pulse with o_increment=0x00100000, o_overflow=0.
REQ-033 Wrap-around: 17 samples starting at 0xFFF80 with step 0x100 -> o_increment=0x00100000, no overflow.
REQ-034 Overflow: one delta of 0x80000 inside a window -> o_overflow=1, o_increment=0x7FFFFFFF; the next clean window gives o_overflow=0.
REQ-035 Backpressure: i_ready=0 for 5 cycles after o_valid -> outputs stay stable and those samples are not counted; after the handshake, 16 further samples are needed for the next o_valid.
REQ-036 Gaps and reset: i_ce toggling 1/0 gives the same result as REQ-032 at half the rate; i_reset after 8 deltas -> the next o_valid needs 17 new samples.
